// File: rtl/pwm_btn_conditioner_pkg.sv
// Shared definitions for the push-button front end of pwm_gen:
// repeat-FSM state encoding, default timing constants and counter sizing.
package pwm_btn_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  // Defaults assume a 100 MHz clock; pwm_gen benches use the same values.
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_RATE     = 10_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit on top of the largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/pwm_btn_conditioner_ch.sv
// One button channel: 2-FF synchroniser, debounce counter and the
// press / hold / auto-repeat FSM that produces raw step pulses.
module btn_debounce_ch
  import pwm_btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync_q;
  logic             r_stable;
  logic [CNT_W-1:0] r_dcnt;

  btn_state_e       r_state;
  btn_state_e       w_state_next;
  logic [CNT_W-1:0] r_rcnt;
  logic [CNT_W-1:0] w_rcnt_next;
  logic             w_pulse;

  // Raw input is only ever seen by r_sync1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync_q <= 1'b0;
      r_stable <= 1'b0;
      r_dcnt   <= '0;
    end else begin
      r_sync1  <= i_btn;
      r_sync_q <= r_sync1;
      if (r_sync_q == r_stable) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DB_LAST) begin
        r_stable <= r_sync_q;
        r_dcnt   <= '0;
      end else begin
        r_dcnt <= r_dcnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_rcnt  <= w_rcnt_next;
    end
  end

  // A fall of the debounced level always wins over a pending repeat.
  always_comb begin
    w_state_next = r_state;
    w_rcnt_next  = r_rcnt;
    w_pulse      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_stable) begin
          w_state_next = ST_HOLD;
          w_rcnt_next  = '0;
          w_pulse      = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!r_stable) begin
          w_state_next = ST_IDLE;
          w_rcnt_next  = '0;
        end else if (REPEAT_EN) begin
          if (r_rcnt == RD_LAST) begin
            w_state_next = ST_REPEAT;
            w_rcnt_next  = '0;
            w_pulse      = 1'b1;
          end else begin
            w_rcnt_next = r_rcnt + CNT_ONE;
          end
        end
      end
      ST_REPEAT: begin
        if (!r_stable) begin
          w_state_next = ST_IDLE;
          w_rcnt_next  = '0;
        end else if (r_rcnt == RR_LAST) begin
          w_rcnt_next = '0;
          w_pulse     = 1'b1;
        end else begin
          w_rcnt_next = r_rcnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_rcnt_next  = '0;
      end
    endcase
  end

  assign o_pulse = w_pulse;
  assign o_level = r_stable;

endmodule

// File: rtl/pwm_btn_conditioner.sv
// Two debounced button channels feeding pwm_gen step inputs; the top adds
// the up/down conflict suppression and the registered pulse outputs.
module pwm_btn_conditioner
  import pwm_btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_up,
  input  logic i_btn_down,
  output logic o_increase,
  output logic o_decrease,
  output logic o_up_held,
  output logic o_down_held
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

  logic [1:0] w_btn;
  logic [1:0] w_pulse;
  logic [1:0] w_level;
  logic       w_both_held;
  logic       w_inc;
  logic       w_dec;
  logic       r_increase;
  logic       r_decrease;

  assign w_btn = {i_btn_down, i_btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      btn_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (REPEAT_EN),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .CNT_W          (CNT_W)
      ) u_ch (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (w_btn[gi]),
        .o_pulse(w_pulse[gi]),
        .o_level(w_level[gi])
      );
    end
  endgenerate

  // Pulses suppressed here are lost for good; the FSMs are not stalled.
  assign w_both_held = &w_level;
  assign w_inc       = w_pulse[0] & ~w_pulse[1] & ~w_both_held;
  assign w_dec       = w_pulse[1] & ~w_pulse[0] & ~w_both_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_increase <= 1'b0;
      r_decrease <= 1'b0;
    end else begin
      r_increase <= w_inc;
      r_decrease <= w_dec;
    end
  end

  assign o_increase  = r_increase;
  assign o_decrease  = r_decrease;
  assign o_up_held   = w_level[0];
  assign o_down_held = w_level[1];

endmodule

// File: tb/tb_pwm_btn_conditioner.sv
// Scoreboard bench: two conditioners (auto-repeat on / off) share one
// stimulus; expected pulse cycles are queued as buttons are driven.
module tb_pwm_btn_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;

  logic inc_rep, dec_rep, uph_rep, dnh_rep;
  logic inc_one, dec_one, uph_one, dnh_one;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int ch;
    int at;
  } exp_t;
  exp_t sb[$];

  string names[4] = '{"inc_rep", "dec_rep", "inc_one", "dec_one"};
  logic [3:0] obs;
  bit hit;

  pwm_btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) dut_rep (
    .clk(clk), .reset(reset), .i_btn_up(btn_up), .i_btn_down(btn_down),
    .o_increase(inc_rep), .o_decrease(dec_rep),
    .o_up_held(uph_rep), .o_down_held(dnh_rep)
  );

  pwm_btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) dut_one (
    .clk(clk), .reset(reset), .i_btn_up(btn_up), .i_btn_down(btn_down),
    .o_increase(inc_one), .o_decrease(dec_one),
    .o_up_held(uph_one), .o_down_held(dnh_one)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic expect_pulse(input int ch, input int at);
    exp_t e;
    e.ch = ch;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_inc_rep"}, int'(inc_rep), 0);
    check({tag, "_dec_rep"}, int'(dec_rep), 0);
    check({tag, "_inc_one"}, int'(inc_one), 0);
    check({tag, "_dec_one"}, int'(dec_one), 0);
  endtask

  // Every output pulse must match a queued expectation at exactly that cycle;
  // an expectation whose cycle arrives without a pulse is reported there.
  always @(negedge clk) begin
    obs = {dec_one, inc_one, dec_rep, inc_rep};
    for (int ch = 0; ch < 4; ch++) begin
      hit = 1'b0;
      for (int k = 0; k < sb.size(); k++) begin
        if (!hit && sb[k].ch == ch && sb[k].at == cyc) begin
          hit = 1'b1;
          sb.delete(k);
        end
      end
      if (hit) begin
        check($sformatf("%s_pulse@%0d", names[ch], cyc), int'(obs[ch]), 1);
        if (obs[ch]) $display("[%0d] %s pulse matched", cyc, names[ch]);
      end else if (obs[ch] !== 1'b0) begin
        check($sformatf("%s_unexpected@%0d", names[ch], cyc), int'(obs[ch]), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check_quiet("rst");
    check("rst_uph_rep", int'(uph_rep), 0);
    check("rst_dnh_rep", int'(dnh_rep), 0);
    check("rst_uph_one", int'(uph_one), 0);
    check("rst_dnh_one", int'(dnh_one), 0);
    reset = 1'b0;
    step();
    check_quiet("post_rst");
    wait_until(10);

    // 1: clean press, 10 cycles
    p = cyc;
    btn_up = 1'b1;
    expect_pulse(0, p + 7);
    expect_pulse(2, p + 7);
    wait_until(p + 5);
    check("t1_held_early", int'(uph_rep), 0);
    wait_until(p + 6);
    check("t1_held_rep", int'(uph_rep), 1);
    check("t1_held_one", int'(uph_one), 1);
    wait_until(p + 10);
    btn_up = 1'b0;
    wait_until(p + 16);
    check("t1_released", int'(uph_rep), 0);
    wait_until(p + 30);

    // 2: bouncing down button
    p = cyc;
    btn_down = 1'b1; step();
    btn_down = 1'b0; step();
    btn_down = 1'b1; step();
    btn_down = 1'b0; step();
    btn_down = 1'b1;
    p = cyc;
    expect_pulse(1, p + 7);
    expect_pulse(3, p + 7);
    wait_until(p + 5);
    check("t2_held_early", int'(dnh_rep), 0);
    wait_until(p + 6);
    check("t2_held", int'(dnh_rep), 1);
    wait_until(p + 12);
    btn_down = 1'b0;
    wait_until(p + 18);
    check("t2_released", int'(dnh_one), 0);
    wait_until(p + 35);

    // 3: auto-repeat, held 60 cycles
    p = cyc;
    btn_up = 1'b1;
    expect_pulse(0, p + 7);
    expect_pulse(0, p + 27);
    expect_pulse(0, p + 35);
    expect_pulse(0, p + 43);
    expect_pulse(0, p + 51);
    expect_pulse(0, p + 59);
    expect_pulse(2, p + 7);
    wait_until(p + 60);
    btn_up = 1'b0;
    wait_until(p + 90);

    // 4: conflict, down pressed 3 cycles after up
    p = cyc;
    btn_up = 1'b1;
    expect_pulse(0, p + 7);
    expect_pulse(2, p + 7);
    wait_until(p + 3);
    btn_down = 1'b1;
    wait_until(p + 10);
    check("t4_both_up", int'(uph_rep), 1);
    check("t4_both_dn", int'(dnh_rep), 1);
    wait_until(p + 33);
    btn_up = 1'b0;
    btn_down = 1'b0;
    wait_until(p + 60);

    // 5: reset in the middle of a hold
    p = cyc;
    btn_up = 1'b1;
    expect_pulse(0, p + 7);
    expect_pulse(2, p + 7);
    wait_until(p + 15);
    reset = 1'b1;
    step();
    check_quiet("t5_rst_a");
    check("t5_rst_held", int'(uph_rep), 0);
    step();
    check_quiet("t5_rst_b");
    reset = 1'b0;
    expect_pulse(0, p + 24);
    expect_pulse(2, p + 24);
    step();
    check_quiet("t5_post_rst");
    check("t5_post_rst_held", int'(uph_one), 0);
    wait_until(p + 30);
    btn_up = 1'b0;
    wait_until(p + 55);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
